// File: rtl/rv_boot_pkg.sv
// Shared definitions for the RV32I boot/run controller.
package rv_boot_pkg;

  localparam int IMEM_WORDS_DEF = 64;
  localparam int MAX_CYCLES_DEF = 1000;
  localparam int RST_CYCLES_DEF = 2;

  localparam logic [31:0] EBREAK_INST = 32'h00100073;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_RESET_CPU = 3'd2,
    ST_RUN       = 3'd3,
    ST_HALT      = 3'd4
  } boot_state_e;

  // Core reset is held everywhere except while running or frozen at halt.
  function automatic logic core_in_reset(input boot_state_e s);
    return (s != ST_RUN) && (s != ST_HALT);
  endfunction

  // States in which a load/run sequence is in progress.
  function automatic logic seq_active(input boot_state_e s);
    return (s == ST_LOAD) || (s == ST_RESET_CPU) || (s == ST_RUN);
  endfunction

endpackage

// File: rtl/byte_word_packer.sv
// Assembles little-endian byte stream into 32-bit words; pulses word_valid
// combinationally on the handshake that supplies the 4th byte.
module byte_word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  byte_idx;
  logic [23:0] asm_q;

  // Byte lane counter and storage for the lower three lanes; a clear drops
  // any partially assembled word.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      byte_idx <= 2'd0;
      asm_q    <= 24'd0;
    end else if (in_valid) begin
      byte_idx <= byte_idx + 2'd1;
      if (byte_idx != 2'd3)
        asm_q[{byte_idx, 3'b000} +: 8] <= in_data;
    end
  end

  // The 4th byte goes straight to the top lane so the word is ready the
  // same cycle it completes.
  assign word_valid = in_valid && (byte_idx == 2'd3);
  assign word       = {in_data, asm_q};

endmodule

// File: rtl/imem_boot_ctrl.sv
// Run controller for the single-cycle RV32I core: load IMEM from a byte
// stream, hold core reset, run until EBREAK or cycle limit, then freeze.
module imem_boot_ctrl
  import rv_boot_pkg::*;
#(
  parameter  int IMEM_WORDS = IMEM_WORDS_DEF,
  parameter  int MAX_CYCLES = MAX_CYCLES_DEF,
  parameter  int RST_CYCLES = RST_CYCLES_DEF,
  localparam int AW         = $clog2(IMEM_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW:0]   load_len,
  input  logic          s_valid,
  input  logic [7:0]    s_data,
  output logic          s_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          cpu_reset,
  output logic          cpu_pc_en,
  input  logic [31:0]   cpu_inst,
  input  logic [31:0]   cpu_pc,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [31:0]   cycle_count,
  output logic [31:0]   halt_pc
);

  localparam int          RW        = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [AW:0] WORDS_MAX = (AW+1)'(IMEM_WORDS);
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);
  localparam logic [31:0] CYC_LAST  = 32'(MAX_CYCLES - 1);

  boot_state_e   state, state_d;
  logic [AW:0]   words_total;
  logic [AW:0]   word_idx;
  logic [RW-1:0] rst_cnt;

  logic          start_go;
  logic          hs;
  logic          pk_valid;
  logic [31:0]   pk_word;
  logic          last_word;
  logic          run_ebreak;
  logic          run_limit;

  assign start_go   = start && ((state == ST_IDLE) || (state == ST_HALT));
  assign s_ready    = (state == ST_LOAD);
  assign busy       = seq_active(state);
  assign hs         = s_valid && s_ready;
  assign last_word  = (word_idx + 1'b1) == words_total;
  assign run_ebreak = (cpu_inst == EBREAK_INST);
  assign run_limit  = (cycle_count == CYC_LAST);

  byte_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_go),
    .in_valid   (hs),
    .in_data    (s_data),
    .word_valid (pk_valid),
    .word       (pk_word)
  );

  // Next-state decode.
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE, ST_HALT:
        if (start) state_d = (load_len == '0) ? ST_RESET_CPU : ST_LOAD;
      ST_LOAD:
        if (pk_valid && last_word) state_d = ST_RESET_CPU;
      ST_RESET_CPU:
        if (rst_cnt == RST_LAST) state_d = ST_RUN;
      ST_RUN:
        if (run_ebreak || run_limit) state_d = ST_HALT;
      default:
        state_d = ST_IDLE;
    endcase
  end

  // State register; core controls decode the next state so the core sees
  // each transition on the same edge the controller takes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cpu_reset <= 1'b1;
      cpu_pc_en <= 1'b0;
    end else begin
      state     <= state_d;
      cpu_reset <= core_in_reset(state_d);
      cpu_pc_en <= (state_d == ST_RUN);
    end
  end

  // IMEM write port: registered one cycle behind the completing byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
    end else begin
      imem_we <= pk_valid;
      if (pk_valid) begin
        imem_addr  <= word_idx[AW-1:0];
        imem_wdata <= pk_word;
      end
    end
  end

  // Load bookkeeping: clamped word budget and write pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      words_total <= '0;
      word_idx    <= '0;
    end else if (start_go) begin
      words_total <= (load_len > WORDS_MAX) ? WORDS_MAX : load_len;
      word_idx    <= '0;
    end else if (pk_valid) begin
      word_idx    <= word_idx + 1'b1;
    end
  end

  // Core reset hold counter; idles at zero outside RESET_CPU.
  always_ff @(posedge clk) begin
    if (reset || (state != ST_RESET_CPU)) rst_cnt <= '0;
    else                                  rst_cnt <= rst_cnt + 1'b1;
  end

  // Run accounting and halt capture; EBREAK takes priority over the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count <= 32'd0;
      halt_pc     <= 32'd0;
      done        <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      if (start_go) begin
        done    <= 1'b0;
        timeout <= 1'b0;
      end
      if (state == ST_RESET_CPU) begin
        cycle_count <= 32'd0;
      end else if (state == ST_RUN) begin
        cycle_count <= cycle_count + 32'd1;
        if (run_ebreak) begin
          done    <= 1'b1;
          halt_pc <= cpu_pc;
        end else if (run_limit) begin
          timeout <= 1'b1;
          halt_pc <= cpu_pc;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Randomized bench for imem_boot_ctrl with a tiny core stand-in and an
// instruction-level reference model of load and run behaviour.
module tb_imem_boot_ctrl;
  import rv_boot_pkg::*;

  localparam int IW   = 64;
  localparam int AW   = 6;
  localparam int MAXC = 50;
  localparam int RSTC = 2;
  localparam logic [31:0] JAL_SELF = 32'h0000006f;

  logic          clk, reset, start;
  logic [AW:0]   load_len;
  logic          s_valid;
  logic [7:0]    s_data;
  logic          s_ready, imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_reset, cpu_pc_en;
  logic [31:0]   cpu_inst, cpu_pc;
  logic          busy, done, timeout;
  logic [31:0]   cycle_count, halt_pc;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  imem_boot_ctrl #(.IMEM_WORDS(IW), .MAX_CYCLES(MAXC), .RST_CYCLES(RSTC)) dut (
    .clk(clk), .reset(reset), .start(start), .load_len(load_len),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .cpu_pc_en(cpu_pc_en),
    .cpu_inst(cpu_inst), .cpu_pc(cpu_pc),
    .busy(busy), .done(done), .timeout(timeout),
    .cycle_count(cycle_count), .halt_pc(halt_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Core stand-in: IMEM plus a PC that steps by 4, or holds on jal x0,0.
  logic [31:0] mem [IW];
  logic [31:0] core_pc;
  initial begin
    for (int i = 0; i < IW; i++) mem[i] = 32'd0;
    core_pc = 32'd0;
  end
  always @(posedge clk) begin
    if (imem_we) mem[imem_addr] <= imem_wdata;
    if (cpu_reset) core_pc <= 32'd0;
    else if (cpu_pc_en) core_pc <= (cpu_inst == JAL_SELF) ? core_pc : core_pc + 32'd4;
  end
  assign cpu_inst = mem[core_pc[AW+1:2]];
  assign cpu_pc   = core_pc;

  // Observed IMEM writes.
  logic [AW-1:0] wr_addr_q[$];
  logic [31:0]   wr_data_q[$];
  int            wr_cyc_q[$];
  always @(negedge clk) if (imem_we) begin
    wr_addr_q.push_back(imem_addr);
    wr_data_q.push_back(imem_wdata);
    wr_cyc_q.push_back(cyc);
  end

  // Reference state.
  logic [31:0]   exp_mem [IW];
  logic [AW-1:0] exp_addr_q[$];
  logic [31:0]   exp_data_q[$];
  int            exp_cyc_q[$];
  logic [31:0]   prog_q[$];
  logic [7:0]    tx_q[$];
  initial for (int i = 0; i < IW; i++) exp_mem[i] = 32'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] filler();
    logic [31:0] r;
    r = $urandom();
    return {r[31:7], 7'h13};
  endfunction

  // kind 0: ends in EBREAK, 1: ends in jal-self loop, 2: plain fill
  task automatic build_prog(input int n, input int kind);
    prog_q.delete();
    for (int i = 0; i < n - 1; i++) prog_q.push_back(filler());
    case (kind)
      0:       prog_q.push_back(EBREAK_INST);
      1:       prog_q.push_back(JAL_SELF);
      default: prog_q.push_back(filler());
    endcase
  endtask

  task automatic send_bytes(input int gap_pct, input int nbytes);
    int i, guard;
    logic fire;
    i = 0; guard = 0;
    while (i < nbytes && guard < 5000) begin
      @(negedge clk); guard++;
      if (int'($urandom_range(99)) < gap_pct) s_valid = 1'b0;
      else begin s_valid = 1'b1; s_data = tx_q[i]; end
      fire = s_valid && s_ready;
      @(posedge clk); #1;
      if (fire) begin
        i++;
        if (i % 4 == 0) exp_cyc_q.push_back(cyc);
      end
    end
    s_valid = 1'b0;
    if (i < nbytes) chk("send_stall", i, nbytes);
  endtask

  task automatic compare_writes();
    int n;
    chk("wr_count", wr_addr_q.size(), exp_addr_q.size());
    n = (wr_addr_q.size() < exp_addr_q.size()) ? wr_addr_q.size() : exp_addr_q.size();
    for (int i = 0; i < n; i++) begin
      chk("wr_addr", 32'(wr_addr_q[i]), 32'(exp_addr_q[i]));
      chk("wr_data", wr_data_q[i], exp_data_q[i]);
      if (i < exp_cyc_q.size()) chk("wr_cycle", wr_cyc_q[i], exp_cyc_q[i]);
    end
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    exp_addr_q.delete(); exp_data_q.delete(); exp_cyc_q.delete();
  endtask

  task automatic do_start(input int len);
    @(negedge clk);
    start = 1'b1;
    load_len = len[AW:0];
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_ready", 32'(s_ready), 32'(len != 0));
  endtask

  // Queue the bytes/expected writes for the first n words of prog_q.
  task automatic stage_words(input int n);
    tx_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_mem[i] = prog_q[i];
      exp_addr_q.push_back(i[AW-1:0]);
      exp_data_q.push_back(prog_q[i]);
      for (int b = 0; b < 4; b++) tx_q.push_back(prog_q[i][8*b +: 8]);
    end
  endtask

  task automatic do_load(input int len, input int gap_pct);
    int n;
    n = (len > IW) ? IW : len;
    stage_words(n);
    do_start(len);
    if (n > 0) begin
      send_bytes(gap_pct, 4 * n);
      @(negedge clk);
      chk("ready_drop", 32'(s_ready), 32'd0);
      chk("rst_hold1", 32'(cpu_reset), 32'd1);
    end
    @(negedge clk);
    chk("rst_hold2", 32'(cpu_reset), 32'd1);
    chk("pc_en_hold", 32'(cpu_pc_en), 32'd0);
    @(negedge clk);
    chk("run_rst", 32'(cpu_reset), 32'd0);
    chk("run_pc_en", 32'(cpu_pc_en), 32'd1);
    compare_writes();
  endtask

  task automatic model_run(output logic m_done, output logic m_to,
                           output logic [31:0] m_cnt, output logic [31:0] m_pc);
    logic [31:0] pc, inst;
    pc = 32'd0; m_done = 1'b0; m_to = 1'b0; m_cnt = 32'd0;
    for (int k = 1; k <= MAXC; k++) begin
      inst  = exp_mem[pc[AW+1:2]];
      m_cnt = k;
      if (inst == EBREAK_INST) begin m_done = 1'b1; break; end
      if (k == MAXC)           begin m_to   = 1'b1; break; end
      if (inst != JAL_SELF) pc = pc + 32'd4;
    end
    m_pc = pc;
  endtask

  task automatic check_halt();
    logic m_done, m_to;
    logic [31:0] m_cnt, m_pc;
    int guard;
    model_run(m_done, m_to, m_cnt, m_pc);
    guard = 0;
    while (!(done || timeout) && guard < 3000) begin
      @(negedge clk); guard++;
    end
    chk("halt_seen", 32'(done || timeout), 32'd1);
    chk("done", 32'(done), 32'(m_done));
    chk("timeout", 32'(timeout), 32'(m_to));
    chk("cycle_count", cycle_count, m_cnt);
    chk("halt_pc", halt_pc, m_pc);
    chk("halt_pc_en", 32'(cpu_pc_en), 32'd0);
    chk("halt_busy", 32'(busy), 32'd0);
    chk("halt_rst", 32'(cpu_reset), 32'd0);
    repeat (3) @(negedge clk);
    chk("frozen_count", cycle_count, m_cnt);
    chk("frozen_pc_en", 32'(cpu_pc_en), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; load_len = '0; s_valid = 1'b0; s_data = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_pc_en", 32'(cpu_pc_en), 32'd0);
    chk("rst_ready", 32'(s_ready), 32'd0);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_flags", {30'd0, done, timeout}, 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_count", cycle_count, 32'd0);
    chk("rst_halt_pc", halt_pc, 32'd0);

    // Three words with continuous valid; rest of IMEM is zero -> limit halt.
    prog_q.delete();
    prog_q.push_back(32'h00300B13);
    prog_q.push_back(filler());
    prog_q.push_back(filler());
    do_load(3, 0);
    check_halt();

    // EBREAK at word 5.
    build_prog(6, 0);
    do_load(6, 0);
    check_halt();
    chk("ebreak5_pc", halt_pc, 32'd20);
    chk("ebreak5_cnt", cycle_count, 32'd6);

    // Infinite loop.
    build_prog(4, 1);
    do_load(4, 10);
    check_halt();
    chk("loop_timeout", 32'(timeout), 32'd1);
    chk("loop_cnt", cycle_count, 32'(MAXC));

    // EBREAK fetched on the very last allowed cycle.
    build_prog(MAXC, 0);
    do_load(MAXC, 0);
    check_halt();
    chk("edge_done", 32'(done), 32'd1);
    chk("edge_timeout", 32'(timeout), 32'd0);

    // Reset in the middle of word 1.
    build_prog(3, 2);
    stage_words(1);
    tx_q.delete();
    for (int i = 0; i < 2; i++)
      for (int b = 0; b < 4; b++) tx_q.push_back(prog_q[i][8*b +: 8]);
    do_start(3);
    send_bytes(40, 6);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_ready", 32'(s_ready), 32'd0);
    chk("mid_rst", 32'(cpu_reset), 32'd1);
    chk("mid_we", 32'(imem_we), 32'd0);
    compare_writes();
    build_prog(3, 0);
    do_load(3, 30);
    check_halt();

    // Rerun the existing image.
    do_load(0, 0);
    check_halt();
    chk("rerun_pc", halt_pc, 32'd8);

    // Oversized length clamps to full depth.
    prog_q.delete();
    for (int i = 0; i < IW; i++) prog_q.push_back(filler());
    do_load(IW + 5, 20);
    check_halt();

    // Randomized sequences.
    for (int it = 0; it < 12; it++) begin
      int n, kind, len;
      n    = 1 + int'($urandom_range(19));
      kind = int'($urandom_range(2));
      build_prog(n, kind);
      len  = ($urandom_range(5) == 0) ? 0 : n;
      do_load(len, int'($urandom_range(50)));
      check_halt();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
